sseg_scan_decoder: RTL and testbench
====================================

// Module: sseg_scan_decoder
// PURPOSE
// - Receive side of the multiplexed 7-segment interface: watches the anode scan and cathode bus
//   that the display path drives, and rebuilds the 32-bit hex value shown on the 8 digits.
// - Used for board loopback self-check and as a bench monitor in front of the display path.
// - Inputs are treated as asynchronous. Each frame of 8 distinct digits produces one value update.
// PARAMETERS
// - SYNC_STAGES    2  synchronizer flops on anode/cathode (min 2)
// - SETTLE_CYCLES  4  consecutive stable synced cycles required before a digit is sampled (min 1)
// PORTS
// - clk          in   1   system clock, single clock domain
// - reset        in   1   asynchronous, active-low reset
// - anode        in   8   digit enables, active-low; anode[i]=0 selects digit i (value bits 4i+3:4i)
// - cathode      in   8   segments, active-low; [6:0]={g,f,e,d,c,b,a}, [7]=dp
// - value        out  32  last completed frame
// - frame_valid  out  1   one-cycle pulse when value updates
// - frame_err    out  1   valid with frame_valid: a digit in that frame had an undecodable pattern
// - dp_out       out  8   decimal-point state per digit (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async assert, sync deassert): value=0, frame_valid=0, frame_err=0, dp_out=0.
//   Reset also clears the shadow register, digit mask, error accumulator and settle counter.
// - Synchronizer: SYNC_STAGES flops per bit, then one compare register (prev) used for change detection.
// - FSM, 2 states:
//   - WAIT: count increments while {anode,cathode} equals prev; any change reloads count to 0.
//     - When count reaches SETTLE_CYCLES-1 and anode is exactly one-hot-low: SAMPLE, go to HELD.
//     - Anode all-ones or multi-low: never sampled, stay in WAIT.
//   - HELD: any change in synced {anode,cathode} -> WAIT with count=0. No re-sample of the same dwell.
// - SAMPLE (single edge):
//   - Decode cathode[6:0] to a nibble: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10
//     A:08 b:03 C:46 d:21 E:06 F:0E (hex of gfedcba).
//   - Any other pattern: nibble=0 and the frame error accumulator is set.
//   - Write the nibble into shadow[4i+3:4i] and set mask[i].
// - Frame completion: when the sample makes mask==8'hFF, on the same edge:
//   - value <= shadow with the new nibble merged in; frame_err <= accumulator incl. this sample.
//   - frame_valid=1 for that cycle only; mask and accumulator clear.
// - Resync: sampling digit i with mask[i] already set (scan wrapped before all 8 were seen):
//   - mask <= only bit i; accumulator <= this sample's error only; shadow keeps stale nibbles.
//   - No frame_valid is produced.
// - Latency: a pin change is sampled SYNC_STAGES+SETTLE_CYCLES+1 clk edges after it occurs, if it stays stable.
// - frame_err and value hold until the next completion. frame_valid never asserts two cycles in a row.
// - Settle count saturates (no wrap) while in WAIT. Its width is $clog2(SETTLE_CYCLES+1).
// CONFIGURATION
// - SSEG_DP_CAPTURE_EN defined:
//   - On SAMPLE, cathode[7] is inverted into dp_shadow[i]; dp_out <= dp_shadow at frame completion.
//   - dp is excluded from the validity check.
// - SSEG_DP_CAPTURE_EN undefined:
//   - dp_out is tied to 8'h00 and cathode[7] is ignored, though it still counts as a change for settling.
// TESTING
// - reset=0 mid-operation -> value=0, frame_valid=0, frame_err=0, dp_out=0 immediately, without waiting for clk.
// - Scan 0x12345678, digits 0..7 held 10 clk each -> exactly one frame_valid, value=32'h12345678, frame_err=0.
// - Same scan with digit 2 held only 3 clk -> digit 2 is never sampled, no frame_valid.
//   Next full scan -> value=32'h12345678.
// - Digit 3 cathode=8'hFF (blank) in scan of 0xCAFEF00D -> frame_valid with frame_err=1, value=32'hCAFE000D.
//   Next clean frame -> frame_err=0.
// - Scan digits 0,1,2,0,1..7 -> resync at the second digit 0, one frame_valid after digit 7.
//   No frame_valid earlier.
// - With SSEG_DP_CAPTURE_EN: cathode[7]=0 on digits 0 and 5 -> dp_out=8'h21 at frame_valid.
//   Without the macro: dp_out=8'h00.

Source files
------------

// File: rtl/sseg_scan_decoder_if.sv
// sseg_scan_decoder_if: scanned 7-segment pins and the value rebuilt from them
interface sseg_scan_decoder_if;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic [31:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  dp_out;
  modport master(output anode, cathode, input value, frame_valid, frame_err, dp_out);
  modport slave(input anode, cathode, output value, frame_valid, frame_err, dp_out);
endinterface

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: rebuilds the 32-bit hex value from a scanned 7-seg display; SSEG_DP_CAPTURE_EN adds decimal-point capture
module sseg_scan_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input logic             clk,
  input logic             reset,
  sseg_scan_decoder_if.slave s
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic {WAIT, HELD} state_t;
  state_t        state, state_nxt;
  logic [15:0]   sync_q [SYNC_STAGES];
  logic [15:0]   prev, cur;
  logic [CW-1:0] count, count_nxt;
  logic          changed, one_hot, sample, complete, err, acc, frame_valid, frame_err;
  logic [2:0]    idx;
  logic [3:0]    nib;
  logic [7:0]    mask, bit_i;
  logic [31:0]   shadow, merged, value;
  assign cur     = sync_q[SYNC_STAGES-1];
  assign changed = cur != prev;
  assign one_hot = $onehot(~cur[15:8]);
  assign bit_i   = 8'(1) << idx;
  assign complete = sample && !mask[idx] && ((mask | bit_i) == 8'hFF);
  assign s.value       = value;
  assign s.frame_valid = frame_valid;
  assign s.frame_err   = frame_err;
  // Synchronize the pins and keep the previous synced word for change detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '1;
      prev <= '1;
    end else begin
      sync_q[0] <= {s.anode, s.cathode};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev <= cur;
    end
  // Selected digit index; only meaningful when the anode word is one-hot-low
  always_comb begin
    idx = '0;
    for (int k = 0; k < 8; k++) if (!cur[8+k]) idx = 3'(k);
  end
  // Segment pattern to nibble; unknown patterns decode to 0 and flag an error
  always_comb begin
    nib = 4'h0;
    err = 1'b0;
    case (cur[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: err = 1'b1;
    endcase
  end
  // Shadow value with the digit being sampled merged in
  always_comb begin
    merged = shadow;
    merged[{idx, 2'b00} +: 4] = nib;
  end
  // Settle FSM state and counter registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= WAIT;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  // Count stable cycles in WAIT, sample once per dwell, leave HELD on any pin change
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sample    = 1'b0;
    if (state == WAIT) begin
      count_nxt = changed ? '0 : (count == CW'(SETTLE_CYCLES) ? count : count + 1'b1);
      if (!changed && count == CW'(SETTLE_CYCLES - 1) && one_hot) begin
        sample    = 1'b1;
        state_nxt = HELD;
      end
    end else if (changed) begin
      state_nxt = WAIT;
      count_nxt = '0;
    end
  end
  // Assemble digits into the shadow; publish on a full frame, restart the mask on a scan wrap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shadow      <= '0;
      mask        <= '0;
      acc         <= 1'b0;
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= complete;
      if (sample) begin
        shadow <= merged;
        mask   <= mask[idx] ? bit_i : (complete ? 8'h00 : mask | bit_i);
        acc    <= mask[idx] ? err : (!complete && (acc | err));
      end
      if (complete) begin
        value     <= merged;
        frame_err <= acc | err;
      end
    end
`ifdef SSEG_DP_CAPTURE_EN
  logic [7:0] dp_shadow, dp_merged, dp_q;
  assign dp_merged = (dp_shadow & ~bit_i) | (cur[7] ? 8'h00 : bit_i);
  assign s.dp_out  = dp_q;
  // Capture active-low decimal points per digit and publish them with the frame
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dp_shadow <= '0;
      dp_q      <= '0;
    end else begin
      if (sample) dp_shadow <= dp_merged;
      if (complete) dp_q <= dp_merged;
    end
`else
  assign s.dp_out = 8'h00;
`endif
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb_sseg_scan_decoder: randomized dwell-level model check of the scan decoder
module tb_sseg_scan_decoder;
  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
`ifdef SSEG_DP_CAPTURE_EN
  localparam logic [7:0] DP_LIT = 8'h21;
`else
  localparam logic [7:0] DP_LIT = 8'h00;
`endif
  typedef struct {logic [31:0] v; logic e; logic [7:0] dp; int cyc;} frame_t;
  logic clk = 1'b0;
  logic reset;
  sseg_scan_decoder_if bus();
  sseg_scan_decoder #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE)) dut (.clk(clk), .reset(reset), .s(bus));
  always #5 clk = ~clk;
  logic [6:0]  seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          checks = 0, errors = 0, cyc = 0, frames = 0;
  frame_t      q[$];
  frame_t      exp_cur = '{32'h0, 1'b0, 8'h00, 0};
  logic [31:0] m_shadow = '0;
  logic [7:0]  m_mask = '0, m_dp = '0;
  logic        m_acc = 1'b0, chk_en = 1'b0, prev_fv = 1'b0;
  logic [15:0] last = 16'hFFFF;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // One dwell on the pins; the model decides if it is sampled and what frame results
  task automatic dwell(input logic [7:0] an, input logic [7:0] ca, input int h);
    logic [15:0] w;
    int i;
    logic [3:0] n;
    logic e;
    frame_t f;
    w = {an, ca};
    if (w == last) w[7] = ~w[7];
    last = w;
    if (h >= SETTLE + 1 && $onehot(~w[15:8])) begin
      i = 0;
      for (int k = 0; k < 8; k++) if (!w[8+k]) i = k;
      n = 4'h0;
      e = 1'b1;
      for (int j = 0; j < 16; j++) if (seg[j] == w[6:0]) begin n = 4'(j); e = 1'b0; end
      m_shadow[4*i +: 4] = n;
      m_dp[i] = ~w[7];
      if (m_mask[i]) begin
        m_mask = 8'(1) << i;
        m_acc = e;
      end else begin
        m_mask[i] = 1'b1;
        m_acc = m_acc | e;
        if (m_mask == 8'hFF) begin
          f.v = m_shadow;
          f.e = m_acc;
`ifdef SSEG_DP_CAPTURE_EN
          f.dp = m_dp;
`else
          f.dp = 8'h00;
`endif
          f.cyc = cyc + SYNC + SETTLE + 1;
          q.push_back(f);
          m_mask = '0;
          m_acc = 1'b0;
        end
      end
    end
    bus.anode = w[15:8];
    bus.cathode = w[7:0];
    repeat (h) @(negedge clk);
  endtask
  task automatic scan(input logic [31:0] v, input logic [7:0] dpm, input int short_d, input int bad_d);
    for (int d = 0; d < 8; d++)
      dwell(~(8'(1) << d), d == bad_d ? 8'hFF : {~dpm[d], seg[v[4*d +: 4]]}, d == short_d ? 3 : 10);
    dwell(8'hFF, 8'hFF, 12);
  endtask
  // Compare every cycle: frame timing against the model stamp, outputs against the last frame
  always @(negedge clk) begin
    if (reset && chk_en) begin
      if (bus.frame_valid) begin
        chk("fv_back_to_back", 64'(prev_fv), 64'(0));
        chk("frame_expected", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          exp_cur = q.pop_front();
          chk("frame_cycle", 64'(cyc), 64'(exp_cur.cyc));
          frames++;
        end
      end
      chk("outputs", {bus.value, bus.frame_err, bus.dp_out}, {exp_cur.v, exp_cur.e, exp_cur.dp});
      prev_fv = bus.frame_valid;
    end else prev_fv = 1'b0;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int f0, ptr, r, h, a, b;
    logic [7:0] an, ca;
    int seq [11] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7};
    reset = 1'b0;
    bus.anode = 8'hFF;
    bus.cathode = 8'hFF;
    #1;
    chk("reset_value", 64'(bus.value), 64'(0));
    chk("reset_fv", 64'(bus.frame_valid), 64'(0));
    chk("reset_err", 64'(bus.frame_err), 64'(0));
    chk("reset_dp", 64'(bus.dp_out), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    f0 = frames;
    scan(32'h12345678, 8'h00, -1, -1);
    chk("scan1_frames", 64'(frames - f0), 64'(1));
    chk("scan1_value", 64'(bus.value), 64'h12345678);
    chk("scan1_err", 64'(bus.frame_err), 64'(0));
    f0 = frames;
    scan(32'h12345678, 8'h00, 2, -1);
    chk("short_frames", 64'(frames - f0), 64'(0));
    f0 = frames;
    scan(32'h12345678, 8'h00, -1, -1);
    chk("rescan_frames", 64'(frames - f0), 64'(1));
    chk("rescan_value", 64'(bus.value), 64'h12345678);
    scan(32'hCAFEF00D, 8'h00, -1, 3);
    chk("blank_value", 64'(bus.value), 64'hCAFE000D);
    chk("blank_err", 64'(bus.frame_err), 64'(1));
    scan(32'h12345678, 8'h00, -1, -1);
    chk("clean_err", 64'(bus.frame_err), 64'(0));
    f0 = frames;
    for (int k = 0; k < 11; k++) dwell(~(8'(1) << seq[k]), {1'b1, seg[4'hF - 4'(seq[k])]}, 10);
    dwell(8'hFF, 8'hFF, 12);
    chk("resync_frames", 64'(frames - f0), 64'(1));
    chk("resync_value", 64'(bus.value), 64'h89ABCDEF);
    scan(32'h0F0F0F0F, 8'h21, -1, -1);
    chk("dp_lit", 64'(bus.dp_out), 64'(DP_LIT));
    for (int d = 0; d < 3; d++) dwell(~(8'(1) << d), {1'b1, seg[4'(d + 9)]}, 10);
    chk("q_empty_at_reset", 64'(q.size()), 64'(0));
    #2 reset = 1'b0;
    #1;
    chk("async_value", 64'(bus.value), 64'(0));
    chk("async_fv", 64'(bus.frame_valid), 64'(0));
    chk("async_err", 64'(bus.frame_err), 64'(0));
    chk("async_dp", 64'(bus.dp_out), 64'(0));
    m_shadow = '0;
    m_mask = '0;
    m_dp = '0;
    m_acc = 1'b0;
    exp_cur = '{32'h0, 1'b0, 8'h00, 0};
    q.delete();
    last = 16'hFFFF;
    bus.anode = 8'hFF;
    bus.cathode = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    scan(32'h0BADF00D, 8'h00, -1, -1);
    chk("post_reset_value", 64'(bus.value), 64'h0BADF00D);
    ptr = 7;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(99);
      h = $urandom_range(12, 3);
      if (r < 75) begin
        ptr = ($urandom_range(9) == 0) ? $urandom_range(7) : (ptr + 1) % 8;
        an = ~(8'(1) << ptr);
        ca = {1'($urandom), seg[$urandom_range(15)]};
      end else if (r < 83) begin
        an = ~(8'(1) << $urandom_range(7));
        ca = 8'($urandom);
      end else if (r < 92) begin
        an = 8'hFF;
        ca = 8'($urandom);
      end else begin
        a = $urandom_range(7);
        b = (a + 1 + $urandom_range(6)) % 8;
        an = ~((8'(1) << a) | (8'(1) << b));
        ca = {1'($urandom), seg[$urandom_range(15)]};
      end
      dwell(an, ca, h);
    end
    dwell(8'hFF, 8'hFF, 20);
    chk("q_empty_at_end", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
